video_linebuf_pp: RTL

- Parametrised ping-pong line memory for the video path; successor to the fixed 1024x32 dual-port video RAM.
- Two line banks of 2^ADDR_W words x DATA_W bits. The writer fills one bank while the reader drains the other.
- Bank hand-over is tracked by an internal 2-entry line queue, with byte enables, a registered read with valid flag, and sticky overflow/underflow flags.
- Sits between the pixel unpacker (write side) and the LCD timing generator (read side), in a single clock domain.

---
 rtl/video_linebuf_pp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/video_linebuf_pp.sv
// Ping-pong line memory: two banks of 2^ADDR_W x DATA_W words with byte enables and a 2-entry line queue.
// Optional macro VIDEO_LINEBUF_OUTREG_EN adds a RAM output register (read latency 2 instead of 1).
module video_linebuf_pp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              wr_line_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_line_done,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        line_count,
  output logic              wr_overflow,
  output logic              rd_underflow
);
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic              wr_bank_reg;
  logic              rd_bank_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic              wr_overflow_reg;
  logic              rd_underflow_reg;
  logic              ram_valid_reg;
  logic              full;
  logic              empty;
  logic              wr_done_ok;
  logic              rd_done_ok;
  logic              wr_word_ok;
  logic [ADDR_W:0]   wr_phys;
  logic [ADDR_W:0]   rd_phys;
  logic [DATA_W-1:0] ram_q;

  assign full       = (count_reg == 2'd2);
  assign empty      = (count_reg == 2'd0);
  assign wr_done_ok = wr_line_done && !full;
  assign rd_done_ok = rd_line_done && !empty;
  assign wr_word_ok = wr_en && !full && !reset;
  assign wr_phys    = {wr_bank_reg, wr_addr};
  assign rd_phys    = {rd_bank_reg, rd_addr};

  assign wr_ready     = !full;
  assign rd_ready     = !empty;
  assign line_count   = count_reg;
  assign wr_overflow  = wr_overflow_reg;
  assign rd_underflow = rd_underflow_reg;

  // Simultaneous accepted pulses cancel out; the full/empty gating decides which side wins.
  always_comb begin
    count_next = count_reg;
    case ({wr_done_ok, rd_done_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg      <= 1'b0;
      rd_bank_reg      <= 1'b0;
      count_reg        <= 2'd0;
      wr_overflow_reg  <= 1'b0;
      rd_underflow_reg <= 1'b0;
      ram_valid_reg    <= 1'b0;
    end else begin
      if (wr_done_ok) wr_bank_reg <= ~wr_bank_reg;
      if (rd_done_ok) rd_bank_reg <= ~rd_bank_reg;
      count_reg <= count_next;
      if (full && (wr_en || wr_line_done)) wr_overflow_reg <= 1'b1;
      if (empty && (rd_en || rd_line_done)) rd_underflow_reg <= 1'b1;
      ram_valid_reg <= rd_en;
    end
  end

  // One RAM per byte lane keeps byte-enable writes mappable to plain block RAM (read-first).
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (wr_word_ok && wr_be[gi]) lane_mem[wr_phys] <= wr_data[8*gi +: 8];
      end

      always_ff @(posedge clk) begin
        if (reset) lane_q_reg <= 8'd0;
        else if (rd_en) lane_q_reg <= lane_mem[rd_phys];
      end

      assign ram_q[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

`ifdef VIDEO_LINEBUF_OUTREG_EN
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= ram_valid_reg;
      if (ram_valid_reg) out_data_reg <= ram_q;
    end
  end

  assign rd_data  = out_data_reg;
  assign rd_valid = out_valid_reg;
`else
  assign rd_data  = ram_q;
  assign rd_valid = ram_valid_reg;
`endif

endmodule
